// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and debug signals of the unified memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          ld_req;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [3:0]    starve_cnt;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  if_req, if_addr,
    input  mem_rdata,
    output ld_gnt, dm_gnt, if_gnt,
    output rvalid, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output starve_cnt
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output if_req, if_addr,
    output mem_rdata,
    input  ld_gnt, dm_gnt, if_gnt,
    input  rvalid, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  starve_cnt
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter for loader, load/store and fetch with fetch anti-starvation
module mem_port_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk1,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);
  localparam logic [3:0] STARVE_TH = 4'(STARVE_MAX);

  logic          ld_gnt;
  logic          dm_gnt;
  logic          if_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    cnt_d;
  logic [3:0]    cnt_q;
  logic          boost_d;
  logic          boost_q;
  logic [2:0]    rvalid_d;
  logic [2:0]    rvalid_q;

  // Grants depend only on requests and registered boost, never on mem_rdata.
  always_comb begin
    ld_gnt = 1'b0;
    dm_gnt = 1'b0;
    if_gnt = 1'b0;
    if (!rst) begin
      if (bus.ld_req) begin
        ld_gnt = 1'b1;
      end else if (bus.if_req && (boost_q || !bus.dm_req)) begin
        if_gnt = 1'b1;
      end else if (bus.dm_req) begin
        dm_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = bus.if_addr;
    mem_wdata = bus.dm_wdata;
    if (ld_gnt) begin
      mem_we    = bus.ld_we;
      mem_addr  = bus.ld_addr;
      mem_wdata = bus.ld_wdata;
    end else if (dm_gnt) begin
      mem_we    = bus.dm_we;
      mem_addr  = bus.dm_addr;
      mem_wdata = bus.dm_wdata;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (if_gnt || !bus.if_req) begin
      cnt_d = 4'd0;
    end else if (cnt_q != 4'hF) begin
      cnt_d = cnt_q + 4'd1;
    end
    boost_d  = (cnt_d >= STARVE_TH);
    rvalid_d = {ld_gnt & ~bus.ld_we, dm_gnt & ~bus.dm_we, if_gnt};
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      cnt_q    <= 4'd0;
      boost_q  <= 1'b0;
      rvalid_q <= 3'b000;
    end else begin
      cnt_q    <= cnt_d;
      boost_q  <= boost_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign bus.ld_gnt     = ld_gnt;
  assign bus.dm_gnt     = dm_gnt;
  assign bus.if_gnt     = if_gnt;
  assign bus.mem_en     = ld_gnt | dm_gnt | if_gnt;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = bus.mem_rdata;
  assign bus.starve_cnt = cnt_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed and randomized checks of mem_port_arbiter against a reference model
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  always #5 clk1 = ~clk1;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  logic          r_ld_req = 1'b0, r_ld_we = 1'b0;
  logic [AW-1:0] r_ld_addr = '0;
  logic [DW-1:0] r_ld_wdata = '0;
  logic          r_dm_req = 1'b0, r_dm_we = 1'b0;
  logic [AW-1:0] r_dm_addr = '0;
  logic [DW-1:0] r_dm_wdata = '0;
  logic          r_if_req = 1'b0;
  logic [AW-1:0] r_if_addr = '0;

  assign bus.ld_req   = r_ld_req;
  assign bus.ld_we    = r_ld_we;
  assign bus.ld_addr  = r_ld_addr;
  assign bus.ld_wdata = r_ld_wdata;
  assign bus.dm_req   = r_dm_req;
  assign bus.dm_we    = r_dm_we;
  assign bus.dm_addr  = r_dm_addr;
  assign bus.dm_wdata = r_dm_wdata;
  assign bus.if_req   = r_if_req;
  assign bus.if_addr  = r_if_addr;

  // Synchronous-read memory behind the arbiter
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd_q;
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rd_q <= mem[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rd_q;

  // Reference model state
  logic [DW-1:0] ref_mem [1024];
  int            m_cnt = 0;
  bit            m_boost = 1'b0;
  logic [2:0]    exp_rv = 3'b000;
  logic [DW-1:0] exp_rdata = '0;
  logic [2:0]    last_gnt = 3'b000;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check DUT against the model at negedge, then advance the model
  task automatic step();
    logic [2:0]    eg;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk1);
    eg = 3'b000;
    if (r_ld_req)                             eg = 3'b100;
    else if (r_if_req && (m_boost || !r_dm_req)) eg = 3'b001;
    else if (r_dm_req)                        eg = 3'b010;
    w = 1'b0; a = r_if_addr; d = '0;
    if (eg[2]) begin w = r_ld_we; a = r_ld_addr; d = r_ld_wdata; end
    if (eg[1]) begin w = r_dm_we; a = r_dm_addr; d = r_dm_wdata; end
    chk("gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, eg);
    chk("rvalid", bus.rvalid, exp_rv);
    if (exp_rv != 3'b000) chk("rdata", bus.rdata, exp_rdata);
    chk("starve_cnt", bus.starve_cnt, m_cnt[3:0]);
    chk("mem_en", bus.mem_en, |eg);
    if (eg != 3'b000) begin
      chk("mem_we", bus.mem_we, w);
      chk("mem_addr", bus.mem_addr, a);
      if (w) chk("mem_wdata", bus.mem_wdata, d);
    end else begin
      chk("mem_we idle", bus.mem_we, 1'b0);
    end
    exp_rv = (eg != 3'b000 && !w) ? eg : 3'b000;
    if (eg != 3'b000 && !w) exp_rdata = ref_mem[a];
    if (eg != 3'b000 && w)  ref_mem[a] = d;
    if (eg[0] || !r_if_req) m_cnt = 0;
    else if (m_cnt < 15)    m_cnt = m_cnt + 1;
    m_boost  = (m_cnt >= STARVE_MAX);
    last_gnt = eg;
    @(posedge clk1);
    #1;
    if (eg[2]) r_ld_req = 1'b0;
    if (eg[1]) r_dm_req = 1'b0;
    if (eg[0]) r_if_req = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] v;
    // Reset state with every requester asserting
    r_ld_req = 1'b1; r_dm_req = 1'b1; r_if_req = 1'b1;
    @(negedge clk1);
    chk("reset gnt", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 3'b000);
    chk("reset mem_en", bus.mem_en, 1'b0);
    chk("reset rvalid", bus.rvalid, 3'b000);
    chk("reset starve_cnt", bus.starve_cnt, 4'd0);
    @(posedge clk1); #1;
    r_ld_req = 1'b0; r_dm_req = 1'b0; r_if_req = 1'b0;
    rst = 1'b0;

    // Preload through the loader
    for (int i = 0; i < 32; i++) begin
      v = (i == 5) ? 32'hDEADBEEF : $urandom;
      r_ld_req = 1'b1; r_ld_we = 1'b1; r_ld_addr = AW'(i); r_ld_wdata = v;
      step();
    end

    // Reset raised in the same cycle as a fetch read grant
    r_if_req = 1'b1; r_if_addr = 10'h005;
    @(negedge clk1);
    chk("t1 gnt before rst", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 3'b001);
    #2 rst = 1'b1;
    #1 chk("t1 gnt in rst", {bus.ld_gnt, bus.dm_gnt, bus.if_gnt}, 3'b000);
    chk("t1 mem_en in rst", bus.mem_en, 1'b0);
    @(negedge clk1);
    chk("t1 rvalid in rst", bus.rvalid, 3'b000);
    chk("t1 starve_cnt in rst", bus.starve_cnt, 4'd0);
    @(posedge clk1); #1;
    rst = 1'b0;
    m_cnt = 0; m_boost = 1'b0; exp_rv = 3'b000;
    step();
    chk("t1 regrant after rst", last_gnt, 3'b001);

    // Read latency: fetch of preloaded 0x005
    r_if_req = 1'b1; r_if_addr = 10'h005;
    step();
    chk("t3 rvalid", bus.rvalid, 3'b001);
    chk("t3 rdata", bus.rdata, 32'hDEADBEEF);

    // Fixed priority ld > dm > if
    r_ld_req = 1'b1; r_ld_we = 1'b0; r_ld_addr = 10'h001;
    r_dm_req = 1'b1; r_dm_we = 1'b0; r_dm_addr = 10'h002;
    r_if_req = 1'b1; r_if_addr = 10'h003;
    step(); chk("t2 ld first", last_gnt, 3'b100);
    step(); chk("t2 dm second", last_gnt, 3'b010);
    step(); chk("t2 if third", last_gnt, 3'b001);
    step();

    // Starvation boost under sustained dm traffic
    for (int c = 1; c <= 10; c++) begin
      r_dm_req = 1'b1; r_dm_we = 1'b0; r_dm_addr = AW'($urandom_range(0, 31));
      r_if_req = 1'b1; r_if_addr = AW'($urandom_range(0, 31));
      step();
      if (c == 4) chk("t4 dm cycle4", last_gnt, 3'b010);
      if (c == 5) chk("t4 if cycle5", last_gnt, 3'b001);
      if (c == 6) chk("t4 dm cycle6", last_gnt, 3'b010);
    end
    r_dm_req = 1'b0; r_if_req = 1'b0;
    step(); step();

    // Store then fetch of the top address
    r_dm_req = 1'b1; r_dm_we = 1'b1; r_dm_addr = 10'h3FF; r_dm_wdata = 32'h0000ABCD;
    step();
    r_if_req = 1'b1; r_if_addr = 10'h3FF;
    step();
    chk("t5 rvalid", bus.rvalid, 3'b001);
    chk("t5 rdata", bus.rdata, 32'h0000ABCD);

    // Back-to-back dm reads
    for (int k = 0; k < 3; k++) begin
      r_dm_req = 1'b1; r_dm_we = 1'b0; r_dm_addr = AW'(16 + k);
      step();
      chk("t6 rvalid", bus.rvalid, 3'b010);
      chk("t6 rdata", bus.rdata, ref_mem[16 + k]);
    end
    step();

    // Loader monopoly saturates the counter
    for (int c = 0; c < 20; c++) begin
      r_ld_req = 1'b1; r_ld_we = 1'b1; r_ld_addr = AW'($urandom_range(0, 31)); r_ld_wdata = $urandom;
      r_if_req = 1'b1; r_dm_req = 1'b1; r_dm_we = 1'b0;
      step();
    end
    chk("sat starve_cnt", bus.starve_cnt, 4'd15);
    r_ld_req = 1'b0;
    step(); step();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      if (!r_ld_req && $urandom_range(0, 7) == 0) begin
        r_ld_req = 1'b1; r_ld_we = 1'($urandom); r_ld_addr = AW'($urandom_range(0, 31)); r_ld_wdata = $urandom;
      end
      if (!r_dm_req && $urandom_range(0, 1) == 0) begin
        r_dm_req = 1'b1; r_dm_we = 1'($urandom);
        r_dm_addr = ($urandom_range(0, 9) == 0) ? 10'h3FF : AW'($urandom_range(0, 31));
        r_dm_wdata = $urandom;
      end
      if (!r_if_req && $urandom_range(0, 3) != 0) begin
        r_if_req = 1'b1; r_if_addr = AW'($urandom_range(0, 31));
      end
      step();
    end
    r_ld_req = 1'b0; r_dm_req = 1'b0; r_if_req = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
